// File: rtl/echo_result_averager.sv
// Batch averager between Echo_Correlation and UART_TX: accumulates 2^AVG_LOG2
// accepted tof/peak pairs and publishes one rounded mean per batch.
module echo_result_averager #(
  parameter int AVG_LOG2 = 3,
  parameter int TOF_W    = 20,
  parameter int PEAK_W   = 18
) (
  input  logic                clk_50M,
  input  logic                rst_n,
  input  logic [TOF_W-1:0]    echo_tof,
  input  logic [PEAK_W-1:0]   echo_peak,
  input  logic                processing_done,
  input  logic [PEAK_W-1:0]   min_peak,
  input  logic                clear,
  output logic [TOF_W-1:0]    avg_tof,
  output logic [PEAK_W-1:0]   avg_peak,
  output logic                avg_valid,
  output logic [AVG_LOG2:0]   batch_cnt,
  output logic [7:0]          reject_cnt
);

  localparam int N   = 1 << AVG_LOG2;
  localparam int CW  = AVG_LOG2 + 1;
  localparam int STW = TOF_W + AVG_LOG2;
  localparam int SPW = PEAK_W + AVG_LOG2;
  localparam logic [CW-1:0]  N_CNT  = CW'(N);
  localparam logic [STW-1:0] HALF_T = STW'(N / 2);
  localparam logic [SPW-1:0] HALF_P = SPW'(N / 2);

  typedef enum logic {ACCUM, DONE} state_e;

  state_e             state_q, state_d;
  logic [STW-1:0]     sumTof_q, sumTof_d;
  logic [SPW-1:0]     sumPeak_q, sumPeak_d;
  logic [CW-1:0]      batchCnt_q, batchCnt_d;
  logic [7:0]         rejectCnt_q, rejectCnt_d;
  logic [TOF_W-1:0]   avgTof_q, avgTof_d;
  logic [PEAK_W-1:0]  avgPeak_q, avgPeak_d;
  logic               avgValid_q, avgValid_d;

  logic               accept;
  logic               reject;
  logic [STW-1:0]     roundTof;
  logic [SPW-1:0]     roundPeak;

  assign accept    = processing_done && (echo_tof != '0) && (echo_peak >= min_peak);
  assign reject    = processing_done && !accept;
  assign roundTof  = sumTof_q + HALF_T;
  assign roundPeak = sumPeak_q + HALF_P;

  // DONE publishes and empties the batch first, so a sample arriving in that
  // same cycle lands in the fresh batch instead of being lost.
  always_comb begin
    state_d     = state_q;
    sumTof_d    = sumTof_q;
    sumPeak_d   = sumPeak_q;
    batchCnt_d  = batchCnt_q;
    rejectCnt_d = rejectCnt_q;
    avgTof_d    = avgTof_q;
    avgPeak_d   = avgPeak_q;
    avgValid_d  = 1'b0;

    if (state_q == DONE) begin
      avgTof_d   = TOF_W'(roundTof >> AVG_LOG2);
      avgPeak_d  = PEAK_W'(roundPeak >> AVG_LOG2);
      avgValid_d = 1'b1;
      sumTof_d   = '0;
      sumPeak_d  = '0;
      batchCnt_d = '0;
      state_d    = ACCUM;
    end

    if (clear) begin
      sumTof_d    = '0;
      sumPeak_d   = '0;
      batchCnt_d  = '0;
      rejectCnt_d = '0;
    end else if (accept) begin
      sumTof_d   = sumTof_d + STW'(echo_tof);
      sumPeak_d  = sumPeak_d + SPW'(echo_peak);
      batchCnt_d = batchCnt_d + CW'(1);
      if (batchCnt_d == N_CNT) state_d = DONE;
    end else if (reject && (rejectCnt_q != 8'hFF)) begin
      rejectCnt_d = rejectCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      sumTof_q    <= '0;
      sumPeak_q   <= '0;
      batchCnt_q  <= '0;
      rejectCnt_q <= '0;
      avgTof_q    <= '0;
      avgPeak_q   <= '0;
      avgValid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sumTof_q    <= sumTof_d;
      sumPeak_q   <= sumPeak_d;
      batchCnt_q  <= batchCnt_d;
      rejectCnt_q <= rejectCnt_d;
      avgTof_q    <= avgTof_d;
      avgPeak_q   <= avgPeak_d;
      avgValid_q  <= avgValid_d;
    end
  end

  assign avg_tof    = avgTof_q;
  assign avg_peak   = avgPeak_q;
  assign avg_valid  = avgValid_q;
  assign batch_cnt  = batchCnt_q;
  assign reject_cnt = rejectCnt_q;

endmodule

// File: tb/tb_echo_result_averager.sv
// Bench for echo_result_averager: three batch sizes (8, 2, 64) share one input
// stream and are checked every cycle against a batch-list model.
module tb_echo_result_averager;

  logic        clk_50M = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] echo_tof = '0;
  logic [17:0] echo_peak = '0;
  logic        processing_done = 1'b0;
  logic [17:0] min_peak = '0;
  logic        clear = 1'b0;

  logic [19:0] avgTof0, avgTof1, avgTof6;
  logic [17:0] avgPeak0, avgPeak1, avgPeak6;
  logic        avgValid0, avgValid1, avgValid6;
  logic [3:0]  batchCnt0;
  logic [1:0]  batchCnt1;
  logic [6:0]  batchCnt6;
  logic [7:0]  rejectCnt0, rejectCnt1, rejectCnt6;

  int numCompares = 0;
  int numMiscompares = 0;

  always #10 clk_50M = ~clk_50M;

  echo_result_averager #(.AVG_LOG2(3), .TOF_W(20), .PEAK_W(18)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .echo_tof(echo_tof), .echo_peak(echo_peak),
    .processing_done(processing_done), .min_peak(min_peak), .clear(clear),
    .avg_tof(avgTof0), .avg_peak(avgPeak0), .avg_valid(avgValid0),
    .batch_cnt(batchCnt0), .reject_cnt(rejectCnt0));

  echo_result_averager #(.AVG_LOG2(1), .TOF_W(20), .PEAK_W(18)) dutL1 (
    .clk_50M(clk_50M), .rst_n(rst_n), .echo_tof(echo_tof), .echo_peak(echo_peak),
    .processing_done(processing_done), .min_peak(min_peak), .clear(clear),
    .avg_tof(avgTof1), .avg_peak(avgPeak1), .avg_valid(avgValid1),
    .batch_cnt(batchCnt1), .reject_cnt(rejectCnt1));

  echo_result_averager #(.AVG_LOG2(6), .TOF_W(20), .PEAK_W(18)) dutL6 (
    .clk_50M(clk_50M), .rst_n(rst_n), .echo_tof(echo_tof), .echo_peak(echo_peak),
    .processing_done(processing_done), .min_peak(min_peak), .clear(clear),
    .avg_tof(avgTof6), .avg_peak(avgPeak6), .avg_valid(avgValid6),
    .batch_cnt(batchCnt6), .reject_cnt(rejectCnt6));

  // Model: each instance collects accepted samples; a full batch is averaged
  // by integer division with round-half-up and appears one edge later.
  int     batchSize[3] = '{8, 2, 64};
  longint mSumT[3], mSumP[3], mAvgT[3], mAvgP[3];
  int     mCnt[3], mRej[3];
  bit     mVld[3];
  bit     modelLive = 1'b0;

  task automatic modelStep();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mSumT[k] = 0; mSumP[k] = 0; mAvgT[k] = 0; mAvgP[k] = 0;
        mCnt[k] = 0; mRej[k] = 0; mVld[k] = 1'b0;
      end else begin
        mVld[k] = 1'b0;
        if (mCnt[k] == batchSize[k]) begin
          mAvgT[k] = (mSumT[k] + batchSize[k] / 2) / batchSize[k];
          mAvgP[k] = (mSumP[k] + batchSize[k] / 2) / batchSize[k];
          mVld[k] = 1'b1;
          mSumT[k] = 0; mSumP[k] = 0; mCnt[k] = 0;
        end
        if (clear) begin
          mSumT[k] = 0; mSumP[k] = 0; mCnt[k] = 0; mRej[k] = 0;
        end else if (processing_done) begin
          if (echo_tof != 0 && echo_peak >= min_peak) begin
            mSumT[k] += echo_tof; mSumP[k] += echo_peak; mCnt[k]++;
          end else if (mRej[k] < 255) begin
            mRej[k]++;
          end
        end
      end
    end
    if (!rst_n) modelLive = 1'b1;
  endtask

  initial forever begin
    @(posedge clk_50M);
    modelStep();
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numCompares++;
    if (act !== exp) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk_50M);
    if (modelLive) begin
      checkOutput("n8.avg_tof",     32'(avgTof0),    32'(mAvgT[0]));
      checkOutput("n8.avg_peak",    32'(avgPeak0),   32'(mAvgP[0]));
      checkOutput("n8.avg_valid",   32'(avgValid0),  32'(mVld[0]));
      checkOutput("n8.batch_cnt",   32'(batchCnt0),  32'(mCnt[0]));
      checkOutput("n8.reject_cnt",  32'(rejectCnt0), 32'(mRej[0]));
      checkOutput("n2.avg_tof",     32'(avgTof1),    32'(mAvgT[1]));
      checkOutput("n2.avg_peak",    32'(avgPeak1),   32'(mAvgP[1]));
      checkOutput("n2.avg_valid",   32'(avgValid1),  32'(mVld[1]));
      checkOutput("n2.batch_cnt",   32'(batchCnt1),  32'(mCnt[1]));
      checkOutput("n2.reject_cnt",  32'(rejectCnt1), 32'(mRej[1]));
      checkOutput("n64.avg_tof",    32'(avgTof6),    32'(mAvgT[2]));
      checkOutput("n64.avg_peak",   32'(avgPeak6),   32'(mAvgP[2]));
      checkOutput("n64.avg_valid",  32'(avgValid6),  32'(mVld[2]));
      checkOutput("n64.batch_cnt",  32'(batchCnt6),  32'(mCnt[2]));
      checkOutput("n64.reject_cnt", 32'(rejectCnt6), 32'(mRej[2]));
    end
  end

  // One call is one clock: inputs change at the falling edge, and the task
  // returns just after the rising edge so callers can inspect fresh outputs.
  task automatic applyStimulus(input logic rstn, input logic pd, input logic clr,
                               input logic [19:0] tof, input logic [17:0] peak);
    @(negedge clk_50M);
    rst_n = rstn; processing_done = pd; clear = clr; echo_tof = tof; echo_peak = peak;
    @(posedge clk_50M);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 20'd0, 18'd0);
  endtask

  int kind[13] = '{0, 1, 0, 2, 0, 1, 0, 0, 2, 0, 1, 0, 0};

  initial begin
    int good;
    applyStimulus(1'b0, 1'b0, 1'b0, 20'd0, 18'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 20'd0, 18'd0);
    checkOutput("reset avg_tof", 32'(avgTof0), 32'd0);
    checkOutput("reset batch_cnt", 32'(batchCnt0), 32'd0);

    // basic average
    min_peak = 18'd100;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 20'd1000, 18'd500);
    checkOutput("basic batch_cnt full", 32'(batchCnt0), 32'd8);
    checkOutput("basic valid not yet", 32'(avgValid0), 32'd0);
    idle(1);
    checkOutput("basic valid", 32'(avgValid0), 32'd1);
    checkOutput("basic avg_tof", 32'(avgTof0), 32'd1000);
    checkOutput("basic avg_peak", 32'(avgPeak0), 32'd500);
    checkOutput("basic batch_cnt back", 32'(batchCnt0), 32'd0);
    idle(1);
    checkOutput("basic valid drop", 32'(avgValid0), 32'd0);

    // rounding
    min_peak = 18'd0;
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 20'(i), 18'(i));
    idle(1);
    checkOutput("round avg_tof", 32'(avgTof0), 32'd5);
    checkOutput("round avg_peak", 32'(avgPeak0), 32'd5);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, (i == 8) ? 20'd2 : 20'd1, 18'd1);
    idle(1);
    checkOutput("round down avg_tof", 32'(avgTof0), 32'd1);

    // rejection
    applyStimulus(1'b1, 1'b0, 1'b1, 20'd0, 18'd0);
    min_peak = 18'd300;
    good = 0;
    for (int i = 0; i < 13; i++) begin
      if (kind[i] == 0) begin
        good++;
        applyStimulus(1'b1, 1'b1, 1'b0, 20'(100 * good), 18'd400);
      end else if (kind[i] == 1) begin
        applyStimulus(1'b1, 1'b1, 1'b0, 20'd777, 18'd200);
      end else begin
        applyStimulus(1'b1, 1'b1, 1'b0, 20'd0, 18'd400);
      end
    end
    checkOutput("reject batch_cnt", 32'(batchCnt0), 32'd8);
    checkOutput("reject reject_cnt", 32'(rejectCnt0), 32'd5);
    idle(1);
    checkOutput("reject avg_tof", 32'(avgTof0), 32'd450);
    checkOutput("reject avg_peak", 32'(avgPeak0), 32'd400);

    // back-to-back across a batch boundary
    min_peak = 18'd0;
    for (int n = 1; n <= 10; n++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 20'(n), 18'(n));
      if (n == 9) begin
        checkOutput("b2b valid", 32'(avgValid0), 32'd1);
        checkOutput("b2b avg_tof", 32'(avgTof0), 32'd5);
        checkOutput("b2b batch_cnt in DONE", 32'(batchCnt0), 32'd1);
      end
    end
    checkOutput("b2b batch_cnt", 32'(batchCnt0), 32'd2);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b1, 1'b0, 20'd0, 18'd5);
    checkOutput("reject saturate", 32'(rejectCnt0), 32'd255);

    // clear mid-batch together with a strobe
    applyStimulus(1'b1, 1'b0, 1'b1, 20'd0, 18'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 20'd2000, 18'd2000);
    applyStimulus(1'b1, 1'b1, 1'b0, 20'd0, 18'd2000);
    checkOutput("pre-clear reject_cnt", 32'(rejectCnt0), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 20'd9999, 18'd9999);
    checkOutput("clear batch_cnt", 32'(batchCnt0), 32'd0);
    checkOutput("clear reject_cnt", 32'(rejectCnt0), 32'd0);
    checkOutput("clear avg held", 32'(avgTof0), 32'd5);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 20'd3000, 18'd1500);
    idle(1);
    checkOutput("after clear avg_tof", 32'(avgTof0), 32'd3000);
    checkOutput("after clear avg_peak", 32'(avgPeak0), 32'd1500);

    // reset mid-batch
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 20'd4000, 18'd4000);
    applyStimulus(1'b0, 1'b0, 1'b0, 20'd0, 18'd0);
    checkOutput("mid reset avg_tof", 32'(avgTof0), 32'd0);
    checkOutput("mid reset avg_peak", 32'(avgPeak0), 32'd0);
    checkOutput("mid reset batch_cnt", 32'(batchCnt0), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 20'd777, 18'd333);
    idle(1);
    checkOutput("post reset avg_tof", 32'(avgTof0), 32'd777);
    checkOutput("post reset avg_peak", 32'(avgPeak0), 32'd333);

    // extremes on all three batch sizes
    applyStimulus(1'b0, 1'b0, 1'b0, 20'd0, 18'd0);
    min_peak = 18'h3FFFF;
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 1'b1, 1'b0, 20'hFFFFF, 18'h3FFFF);
    idle(1);
    checkOutput("ext n64 valid", 32'(avgValid6), 32'd1);
    idle(1);
    checkOutput("ext n8 avg_tof", 32'(avgTof0), 32'hFFFFF);
    checkOutput("ext n8 avg_peak", 32'(avgPeak0), 32'h3FFFF);
    checkOutput("ext n2 avg_tof", 32'(avgTof1), 32'hFFFFF);
    checkOutput("ext n2 avg_peak", 32'(avgPeak1), 32'h3FFFF);
    checkOutput("ext n64 avg_tof", 32'(avgTof6), 32'hFFFFF);
    checkOutput("ext n64 avg_peak", 32'(avgPeak6), 32'h3FFFF);

    // randomized traffic
    min_peak = 18'd1000;
    for (int i = 0; i < 4000; i++) begin
      logic [19:0] t;
      logic [17:0] p;
      int sel;
      sel = int'($urandom_range(0, 9));
      t = (sel == 0) ? 20'd0 : (sel == 1) ? 20'hFFFFF : 20'($urandom);
      p = (sel == 2) ? 18'h3FFFF : 18'($urandom_range(0, 8000));
      if ($urandom_range(0, 49) == 0) min_peak = 18'($urandom_range(0, 6000));
      applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 59) == 0), t, p);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", numCompares, numMiscompares);
    $finish;
  end

endmodule

// File: doc/echo_result_averager.md
# echo_result_averager

Averages consecutive echo measurements from `Echo_Correlation` before they reach `UART_TX`, which reduces jitter in the reported time-of-flight and peak values. It sits between the two blocks in the clk_50M domain. On each `processing_done` pulse it either accepts or rejects the `echo_tof`/`echo_peak` pair. After 2^AVG_LOG2 accepted pairs it emits one rounded mean with a one-cycle `avg_valid` pulse, which is wired to `UART_TX.processing_done`.

## Interface
Parameters:
- AVG_LOG2, 3: log2 of batch size N (N=8); legal range 1..6.
- TOF_W, 20: width of echo_tof and avg_tof.
- PEAK_W, 18: width of echo_peak, min_peak and avg_peak.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, synchronous, active-low (sampled on rising clk_50M).
- echo_tof  in  TOF_W  time-of-flight from Echo_Correlation; qualified by processing_done.
- echo_peak  in  PEAK_W  correlation peak from Echo_Correlation; qualified by processing_done.
- processing_done  in  1  one-cycle strobe: measurement valid.
- min_peak  in  PEAK_W  acceptance threshold (quasi-static).
- clear  in  1  one-cycle strobe: discard partial batch and zero reject_cnt.
- avg_tof  out  TOF_W  rounded mean TOF of last completed batch.
- avg_peak  out  PEAK_W  rounded mean peak of last completed batch.
- avg_valid  out  1  one-cycle strobe: avg_tof/avg_peak updated.
- batch_cnt  out  AVG_LOG2+1  accepted samples in current batch (0..N-1 between batches).
- reject_cnt  out  8  rejected samples since reset/clear, saturating at 255.

## Operation
- A sample is accepted when processing_done=1, echo_tof != 0 and echo_peak >= min_peak (unsigned compare).
- A sample is rejected when processing_done=1 and either echo_tof=0 (no echo) or echo_peak < min_peak. A rejection increments reject_cnt (saturating at 255) and leaves the batch untouched.
- Accumulators:
  - sum_tof is TOF_W+AVG_LOG2 bits; sum_peak is PEAK_W+AVG_LOG2 bits.
  - Accumulation is unsigned and cannot overflow for N samples.
- Result: avg = (sum + 2^(AVG_LOG2-1)) >> AVG_LOG2, i.e. round half up.
  - The add is done in the sum width; no overflow is possible because each sample is at most 2^W-1.
  - The result always fits TOF_W/PEAK_W bits.
- State machine, two states:
  - ACCUM: accept/reject as above. On the Nth accept, go to DONE; sums include the Nth sample.
  - DONE (exactly one cycle):
    - Register avg_tof/avg_peak from the sums.
    - Zero sums and batch_cnt.
    - Return to ACCUM.
    - A processing_done in this cycle is still evaluated. If accepted, it becomes sample 1 of the next batch: sums load the sample, batch_cnt=1. If rejected, reject_cnt increments. No sample is ever lost.
- clear:
  - In ACCUM: zero sums, batch_cnt and reject_cnt. avg_tof/avg_peak hold.
  - clear takes priority over a simultaneous processing_done, whose sample is discarded (not counted as a reject).
  - In DONE: the pending result is still published, then the clear behaviour above applies.
- Reset (rst_n=0 on an edge), at any point including mid-batch, sets:
  - state=ACCUM;
  - sums=0, batch_cnt=0, reject_cnt=0;
  - avg_tof=0, avg_peak=0, avg_valid=0.
- min_peak changes take effect for the next evaluated sample.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Let edge E be the one that samples the Nth accept:
  - At E: state becomes DONE and batch_cnt becomes N; sums hold the full batch.
  - At E+1: avg_tof/avg_peak update and avg_valid=1.
  - At E+2: avg_valid=0.
  - avg_valid therefore asserts two clocks after processing_done of the Nth sample.
- avg_tof/avg_peak stay stable until the next avg_valid. This satisfies UART_TX, which samples the data on its done strobe.
- batch_cnt and reject_cnt update on the edge that samples the triggering strobe.
- Maximum input rate: one processing_done per cycle, sustained, with no loss across batch boundaries.
- Throughput: one avg_valid per N accepted samples.

## Test plan
- Basic average: reset, then 8 pulses with tof=1000, peak=500, min_peak=100 → avg_tof=1000, avg_peak=500; avg_valid high exactly once, 2 cycles after the 8th pulse; batch_cnt returns to 0.
- Rounding: tof=1..8 and peak=1..8 → sum 36, (36+4)>>3 gives avg_tof=5 and avg_peak=5. Tof=1,1,1,1,1,1,1,2 → sum 9, (9+4)>>3 gives avg_tof=1.
- Rejection: min_peak=300; interleave 8 good samples (peak=400) with 3 samples at peak=200 and 2 at tof=0 → reject_cnt=5; averages reflect only the 8 good samples; batch_cnt ignores the rejects.
- Back-to-back: 10 consecutive pulses every cycle with tof=n (n=1..10) → first avg_tof=5; batch_cnt=2 afterwards; the 9th sample, arriving in the DONE cycle, is counted. 300 rejects → reject_cnt saturates at 255.
- Clear/reset mid-batch:
  - After 5 accepts, pulse clear together with a processing_done → batch_cnt=0, reject_cnt=0, previous avg held, that sample dropped.
  - Separately, drop rst_n after 5 accepts → all outputs 0; the next 8 samples produce a clean average.
- Extremes: 8 samples with tof=0xFFFFF and peak=0x3FFFF → avg_tof=0xFFFFF, avg_peak=0x3FFFF, no wrap. Repeat with AVG_LOG2=1 and AVG_LOG2=6 for the same result.
